// File: rtl/decode_queue_if.sv
// Fetch-to-controller bus for decode_queue: push side from fetch, decoded head toward the controller.
interface decode_queue_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 9,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [1:0]        alu_op;
  logic [2:0]        cond;
  logic [2:0]        rn;
  logic [2:0]        rm;
  logic [2:0]        rd;
  logic [1:0]        shift;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] sximm8;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, op, alu_op, cond,
           rn, rm, rd, shift, sximm5, sximm8, count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, op, alu_op, cond,
           rn, rm, rd, shift, sximm5, sximm8, count
  );
endinterface

// File: rtl/decode_queue.sv
// DEPTH-entry instruction FIFO that presents its head entry fully decoded,
// decoupling fetch from the multi-cycle controller; flush discards all entries.
module decode_queue #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 9,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           reset_n,
  decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 16 + PC_W;

  function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] v);
    return {{(DATA_W-5){v[4]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full, empty, push, pop;

  // Handshake depends only on registered occupancy, never on same-cycle pop.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid  && !full  && !bus.flush;
  assign pop   = bus.out_ready && !empty && !bus.flush;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; outputs are gated by out_valid so it never leaks.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_instr, bus.in_pc};
  end

  logic [ENT_W-1:0] head;
  logic [15:0]      hi;

  always_comb begin
    head       = mem_q[rd_ptr_q];
    hi         = head[ENT_W-1:PC_W];
    bus.out_pc = '0;
    bus.opcode = '0;
    bus.op     = '0;
    bus.alu_op = '0;
    bus.cond   = '0;
    bus.rn     = '0;
    bus.rm     = '0;
    bus.rd     = '0;
    bus.shift  = '0;
    bus.sximm5 = '0;
    bus.sximm8 = '0;
    if (!empty) begin
      bus.out_pc = head[PC_W-1:0];
      bus.opcode = hi[15:13];
      bus.op     = hi[12:11];
      bus.alu_op = hi[12:11];
      bus.cond   = hi[10:8];
      bus.rn     = hi[10:8];
      bus.rm     = hi[2:0];
      bus.rd     = (hi[15:11] == 5'b11010 || hi[15:11] == 5'b01011) ? hi[10:8] : hi[7:5];
      bus.shift  = (hi[15:13] == 3'b100) ? 2'b00 : hi[4:3];
      bus.sximm5 = sext5(hi[4:0]);
      bus.sximm8 = sext8(hi[7:0]);
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, full/empty edges, flush, async reset, pointer wrap.
module tb_decode_queue;
  localparam int DATA_W = 16;
  localparam int PC_W   = 9;
  localparam int DEPTH  = 4;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_miss;

  decode_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  decode_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] head_instr();
    return {bus.opcode, bus.op, bus.cond, bus.sximm8[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] ins, input logic [PC_W-1:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 0);
    chk({tag, ".ready"}, 32'(bus.in_ready), 1);
    chk({tag, ".count"}, 32'(bus.count), 0);
    chk({tag, ".pc"}, 32'(bus.out_pc), 0);
    chk({tag, ".fields"}, {16'(head_instr()), 4'(0), bus.rd, bus.rm, bus.shift}, 0);
    chk({tag, ".imm5"}, 32'(bus.sximm5), 0);
  endtask

  function automatic logic [15:0] wvec(input int k);
    return 16'hC000 ^ 16'(k * 'h0135);
  endfunction

  initial begin
    n_vec = 0;
    n_miss = 0;
    reset_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk_idle("reset");
    reset_n = 1'b1;

    // Decode of a MOV-immediate style instruction: rd comes from [10:8].
    push(16'b110_10_101_0000_0111, 9'h005);
    chk("t1.valid", 32'(bus.out_valid), 1);
    chk("t1.rd", 32'(bus.rd), 3'b101);
    chk("t1.rn", 32'(bus.rn), 3'b101);
    chk("t1.sximm8", 32'(bus.sximm8), 'h0007);
    chk("t1.pc", 32'(bus.out_pc), 'h005);
    chk("t1.count", 32'(bus.count), 1);
    chk("t1.opcode", 32'(bus.opcode), 3'b110);
    chk("t1.alu_op", 32'(bus.alu_op), 2'b10);
    pop_one();
    chk_idle("t1.drained");

    push(16'b100_00_010_011_11_001, 9'h006);
    chk("t2.shift", 32'(bus.shift), 0);
    chk("t2.rd", 32'(bus.rd), 3'b011);
    chk("t2.rn", 32'(bus.rn), 3'b010);
    chk("t2.rm", 32'(bus.rm), 3'b001);
    pop_one();
    push(16'b101_00_001_010_10_011, 9'h007);
    chk("t3.shift", 32'(bus.shift), 2'b10);
    chk("t3.sximm5", 32'(bus.sximm5), 'hFFF3);
    chk("t3.rd", 32'(bus.rd), 3'b010);
    chk("t3.sximm8", 32'(bus.sximm8), 'h0053);
    pop_one();

    // Overfill with consumer stalled; the fifth instruction must be refused.
    for (int i = 0; i <= DEPTH; i++) begin
      chk($sformatf("fill.ready%0d", i), 32'(bus.in_ready), (i < DEPTH) ? 1 : 0);
      push(16'(16'h1111 * (i + 1)), 9'(9'h100 + i));
    end
    chk("fill.count", 32'(bus.count), DEPTH);
    chk("fill.ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain.valid%0d", i), 32'(bus.out_valid), 1);
      chk($sformatf("drain.instr%0d", i), 32'(head_instr()), 32'(16'h1111 * (i + 1)));
      chk($sformatf("drain.pc%0d", i), 32'(bus.out_pc), 'h100 + i);
      tick();
    end
    bus.out_ready = 1'b0;
    chk_idle("drain.end");

    // Full queue with push and pop together: only the pop happens.
    for (int i = 0; i < DEPTH; i++) push(16'(16'hA0A0 + i), 9'(9'h020 + i));
    bus.in_valid = 1'b1;
    bus.in_instr = 16'hBEEF;
    bus.in_pc = 9'h1EE;
    bus.out_ready = 1'b1;
    chk("fullpp.ready", 32'(bus.in_ready), 0);
    tick();
    bus.out_ready = 1'b0;
    chk("fullpp.count", 32'(bus.count), 3);
    chk("fullpp.ready2", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    chk("fullpp.count2", 32'(bus.count), 4);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("fullpp.instr%0d", i),
          32'(head_instr()), (i < DEPTH) ? 32'(16'hA0A0 + i) : 32'h0000BEEF);
      chk($sformatf("fullpp.pc%0d", i), 32'(bus.out_pc), (i < DEPTH) ? 'h020 + i : 'h1EE);
      tick();
    end
    bus.out_ready = 1'b0;
    chk_idle("fullpp.end");

    // Flush with three entries held and a push/pop offered in the same cycle.
    for (int i = 0; i < 3; i++) push(16'(16'h5A00 + i), 9'(9'h0F0 + i));
    chk("flush.pre", 32'(bus.count), 3);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h7777;
    bus.in_pc = 9'h077;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk_idle("flush");
    push(16'h4242, 9'h042);
    chk("flush.next", 32'(head_instr()), 'h4242);
    chk("flush.nextcnt", 32'(bus.count), 1);
    pop_one();

    // Asynchronous reset between edges with two entries queued.
    push(16'h1234, 9'h011);
    push(16'h5678, 9'h012);
    chk("areset.pre", 32'(bus.count), 2);
    #2 reset_n = 1'b0;
    #1;
    chk_idle("areset");
    #1 reset_n = 1'b1;

    // Streaming push+pop across 2*DEPTH+1 instructions wraps both pointers.
    for (int k = 0; k <= 2 * DEPTH + 1; k++) begin
      bus.in_valid  = (k < 2 * DEPTH + 1);
      bus.in_instr  = wvec(k);
      bus.in_pc     = 9'(9'h040 + k);
      bus.out_ready = (k > 0);
      if (k > 0) begin
        chk($sformatf("wrap.instr%0d", k - 1), 32'(head_instr()), 32'(wvec(k - 1)));
        chk($sformatf("wrap.pc%0d", k - 1), 32'(bus.out_pc), 'h040 + k - 1);
        chk($sformatf("wrap.count%0d", k - 1), 32'(bus.count), 1);
      end else begin
        chk("wrap.start", 32'(bus.count), 0);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk_idle("wrap.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the combinational instruction-field decoder.
- Buffers fetched 16-bit instructions, with their PC, in a DEPTH-entry FIFO.
- Presents the head entry fully decoded (register indices, opcode/op, shift, sign-extended immediates) to the execute-side controller over a valid/ready handshake.
- Sits between fetch and the controller FSM, decoupling fetch from multi-cycle execution, with flush for taken branches.

Parameters:
- DATA_W, 16, width of sximm5/sximm8 outputs (sign extension target); must be >= 8.
- PC_W, 9, width of the PC tag stored with each instruction.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept; equals !full.
- in_instr  input  16  raw instruction.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  consumer accepts the head.
- out_pc  output  PC_W  PC of the head entry.
- opcode  output  3  head instr[15:13].
- op  output  2  head instr[12:11].
- alu_op  output  2  head instr[12:11].
- cond  output  3  head instr[10:8].
- rn  output  3  head instr[10:8].
- rm  output  3  head instr[2:0].
- rd  output  3  instr[10:8] when instr[15:11] is 5'b11010 or 5'b01011; otherwise instr[7:5].
- shift  output  2  2'b00 when instr[15:13] == 3'b100; otherwise instr[4:3].
- sximm5  output  DATA_W  instr[4:0] sign-extended from bit 4.
- sximm8  output  DATA_W  instr[7:0] sign-extended from bit 7.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x (16 + PC_W) register array; write pointer, read pointer, count register; pointers wrap modulo DEPTH.
- Push: occurs when in_valid && in_ready on a rising edge. Pop: occurs when out_valid && out_ready.
- Decode fields are combinational from the head entry only. When out_valid = 0, all decode outputs and out_pc are driven 0, never the stale head.
- Latency: an instruction pushed into an empty queue at edge N is visible with out_valid = 1 after edge N; no same-cycle bypass from in_instr to outputs.
- Ordering: strict FIFO. The instruction/PC pairing is preserved.
- Simultaneous push and pop:
  - Not full and not empty: both occur, count unchanged.
  - Full: push is refused (in_ready = 0) even if a pop happens that cycle; no combinational ready-through-pop path.
  - Empty: only the push occurs.
- in_ready = (count != DEPTH); out_valid = (count != 0). Both are functions of registered state only.
- flush = 1 at an edge:
  - Clears count and both pointers.
  - Any push and pop in that same cycle are ignored.
  - Next cycle out_valid = 0, in_ready = 1.
  - Storage contents are not cleared.
- Push while full: the entry is not written, state is unchanged, and no error is raised (fetch must hold).
- Pop while empty: ignored.
- Reset (reset_n low, asynchronous, including mid-operation):
  - count = 0, pointers = 0, out_valid = 0, in_ready = 1, all decode outputs and out_pc = 0.
  - Storage array need not be reset.
  - After deassertion, the first push is accepted on the first edge with in_valid = 1.
- Arithmetic: count is width $clog2(DEPTH)+1, so DEPTH itself is representable. Pointers are $clog2(DEPTH) wide and wrap naturally.
- No X propagation on outputs after reset in any state.

Test Plan:
- Reset then push 16'b110_10_101_0000_0111 at pc 9'h005, out_ready = 0 -> next cycle out_valid = 1, rd = 3'b101, rn = 3'b101, sximm8 = 16'h0007, out_pc = 9'h005, count = 1.
- Push 16'b100_00_010_011_11_001 -> shift = 2'b00, rd = 3'b011, rn = 3'b010, rm = 3'b001. Push 16'b101_00_001_010_10_011 -> shift = 2'b10, sximm5 = 16'hFFF3, rd = 3'b010.
- Push DEPTH+1 instructions with out_ready = 0 -> in_ready drops after the DEPTH-th accept, count = 4, and the extra instruction is not stored. Then drain with out_ready = 1 -> the DEPTH entries appear in push order, one per cycle.
- Full queue, in_valid = 1 and out_ready = 1 in the same cycle -> pop only, count 4 -> 3, pushed data absent. Next cycle the push is accepted and count = 4.
- Queue holding 3 entries, assert flush with in_valid = 1 -> next cycle count = 0, out_valid = 0, decode outputs 0, and the flushed-cycle instruction never appears.
- Pulse reset_n low asynchronously between edges with 2 entries queued -> count = 0, out_valid = 0, in_ready = 1 immediately. After release, pointer wrap is checked by pushing and popping 2*DEPTH+1 instructions with data integrity preserved.
